// File: rtl/md_pkg.sv
// Shared encodings, state type and default latencies
// for the E-stage multiply/divide sequencer.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int MD_MUL_CYCLES = 5;
  localparam int MD_DIV_CYCLES = 10;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } md_state_e;

  function automatic logic is_mul_op(
    input logic [2:0] op
  );
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div_op(
    input logic [2:0] op
  );
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 32x32 multiply and divide datapath;
// signed division truncates toward zero.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic        sgn;
  logic        rs_neg;
  logic        rt_neg;
  logic [63:0] a64;
  logic [63:0] b64;
  logic [63:0] prod;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [31:0] div_b;
  logic [31:0] uq;
  logic [31:0] ur;

  always_comb begin
    sgn    = (op == MD_MULT) || (op == MD_DIV);
    rs_neg = sgn & rs_val[31];
    rt_neg = sgn & rt_val[31];
    a64    = {{32{rs_neg}}, rs_val};
    b64    = {{32{rt_neg}}, rt_val};
    prod   = a64 * b64;
    a_abs  = rs_neg ? -rs_val : rs_val;
    b_abs  = rt_neg ? -rt_val : rt_val;
    div_zero = is_div_op(op) && (rt_val == 32'd0);
    // keep the divider free of X on a zero divisor
    div_b  = (rt_val == 32'd0) ? 32'd1 : b_abs;
    uq     = a_abs / div_b;
    ur     = a_abs % div_b;
    res_hi = 32'd0;
    res_lo = 32'd0;
    if (is_mul_op(op)) begin
      {res_hi, res_lo} = prod;
    end else if (is_div_op(op)) begin
      res_lo = (rs_neg ^ rt_neg) ? -uq : uq;
      res_hi = rs_neg ? -ur : ur;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// E-stage multiply/divide sequencer: HI/LO pair,
// fixed-latency busy counter and D-stage stall.
module muldiv_ctrl
  import md_pkg::*;
#(
  parameter int MUL_CYCLES = MD_MUL_CYCLES,
  parameter int DIV_CYCLES = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

  md_state_e   state;
  md_state_e   state_n;
  logic [3:0]  cnt;
  logic [3:0]  cnt_n;
  logic [31:0] hi_n;
  logic [31:0] lo_n;
  logic [31:0] pend_hi;
  logic [31:0] pend_hi_n;
  logic [31:0] pend_lo;
  logic [31:0] pend_lo_n;
  logic        pend_dz;
  logic        pend_dz_n;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div_zero;
  logic        is_mul;
  logic        is_div;

  md_arith u_arith (
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  assign is_mul = is_mul_op(op);
  assign is_div = is_div_op(op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_dz <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      hi      <= hi_n;
      lo      <= lo_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
      pend_dz <= pend_dz_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hi_n      = hi;
    lo_n      = lo;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    pend_dz_n = pend_dz;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          unique case (1'b1)
            is_mul: begin
              pend_hi_n = res_hi;
              pend_lo_n = res_lo;
              pend_dz_n = 1'b0;
              cnt_n     = MUL_LOAD;
              state_n   = ST_BUSY;
            end
            is_div: begin
              pend_hi_n = res_hi;
              pend_lo_n = res_lo;
              pend_dz_n = div_zero;
              cnt_n     = DIV_LOAD;
              state_n   = ST_BUSY;
            end
            (op == MD_MTHI): hi_n = rs_val;
            (op == MD_MTLO): lo_n = rs_val;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        if (cnt == 4'd0) begin
          // a zero divisor burns the latency but keeps HI/LO
          if (!pend_dz) begin
            hi_n = pend_hi;
            lo_n = pend_lo;
          end
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
    endcase
  end

  assign busy = (state == ST_BUSY);

  assign stall_md = rst_n & md_use_d &
                    (busy | (start & (is_mul | is_div)));

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed plus randomized bench for muldiv_ctrl
// against a plain-arithmetic HI/LO model.
module tb_muldiv_ctrl;
  import md_pkg::*;

  localparam int MULN = 5;
  localparam int DIVN = 10;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_use_d;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  muldiv_ctrl #(
    .MUL_CYCLES (MULN),
    .DIV_CYCLES (DIVN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .md_use_d (md_use_d),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Reference: what HI/LO must become after the op.
  task automatic model(input logic [2:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    int              ia, ib;
    case (o)
      MD_MULT: begin
        ia = int'(a); ib = int'(b);
        sa = ia; sb = ib;
        sp = sa * sb;
        {m_hi, m_lo} = sp;
      end
      MD_MULTU: begin
        ua = {32'd0, a}; ub = {32'd0, b};
        up = ua * ub;
        {m_hi, m_lo} = up;
      end
      MD_DIV: if (b != 0) begin
        ia = int'(a); ib = int'(b);
        m_lo = ia / ib;
        m_hi = ia % ib;
      end
      MD_DIVU: if (b != 0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
      MD_MTHI: m_hi = a;
      MD_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  // Called at a negedge with the DUT idle.
  task automatic run_arith(input logic [2:0] o,
                           input logic [31:0] a,
                           input logic [31:0] b,
                           input bit ign);
    int n;
    int cyc;
    bit stall_ok;
    n = (o == MD_MULT || o == MD_MULTU) ? MULN : DIVN;
    model(o, a, b);
    start = 1'b1; op = o;
    rs_val = a; rt_val = b;
    md_use_d = 1'b1;
    #1 chk("stall_start", 64'(stall_md), 64'd1);
    @(negedge clk);
    start = 1'b0;
    rs_val = $urandom; rt_val = $urandom;
    cyc = 0;
    stall_ok = 1'b1;
    while (busy && cyc < 20) begin
      if (!stall_md) stall_ok = 1'b0;
      start = ign && (cyc == 1);
      if (ign && cyc == 1) begin
        op = MD_MULTU;
        rs_val = 32'h1234_5678;
        rt_val = 32'h0000_0100;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_len", 64'(cyc), 64'(n));
    chk("stall_busy", 64'(stall_ok), 64'd1);
    chk("hi", 64'(hi), 64'(m_hi));
    chk("lo", 64'(lo), 64'(m_lo));
  endtask

  task automatic run_mt(input logic [2:0] o,
                        input logic [31:0] a);
    model(o, a, 32'd0);
    start = 1'b1; op = o;
    rs_val = a; rt_val = $urandom;
    md_use_d = 1'b1;
    #1 chk("mt_stall", 64'(stall_md), 64'd0);
    @(negedge clk);
    start = 1'b0;
    chk("mt_busy", 64'(busy), 64'd0);
    chk("mt_hi", 64'(hi), 64'(m_hi));
    chk("mt_lo", 64'(lo), 64'(m_lo));
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n = 1'b0;
    start = 1'b1;
    op = MD_MULT;
    rs_val = 32'd5;
    rt_val = 32'd6;
    md_use_d = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(stall_md), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);

    run_arith(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    run_arith(MD_DIVU, 32'd7, 32'd2, 1'b0);
    run_arith(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);

    run_mt(MD_MTHI, 32'h11);
    run_mt(MD_MTLO, 32'h22);
    run_arith(MD_DIV, 32'd1234, 32'd0, 1'b0);
    chk("dz_hi", 64'(hi), 64'h11);
    chk("dz_lo", 64'(lo), 64'h22);

    run_arith(MD_MULT, 32'd1000, 32'hFFFF_FFF0, 1'b1);

    start = 1'b0;
    md_use_d = 1'b1;
    #1 chk("idle_stall", 64'(stall_md), 64'd0);
    @(negedge clk);
    run_mt(MD_MTHI, 32'hABCD);

    // abort a DIV with reset three cycles in
    start = 1'b1; op = MD_DIV;
    rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_stall", 64'(stall_md), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("nocommit_busy", 64'(busy), 64'd0);
    chk("nocommit_hi", 64'(hi), 64'd0);
    chk("nocommit_lo", 64'(lo), 64'd0);

    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 5));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 5) == 0) rb = 32'($urandom_range(1, 9));
      if (ro == MD_DIV && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)
        rb = 32'd1;
      if (ro <= MD_DIVU) run_arith(ro, ra, rb, 1'(i % 4 == 0));
      else run_mt(ro, ra);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
